dmem_vec_responder: RTL

//  Data-memory responder on the memory side of the single-cycle core's data port:

---
 rtl/dmem_vec_responder_pkg.sv | 10 +
 rtl/dmem_vec_responder_vec_store_buffer.sv | 77 +++++++
 rtl/dmem_vec_responder.sv | 102 ++++++++++
 3 files changed

// File: rtl/dmem_vec_responder_pkg.sv
// Shared types and constants for the data-memory responder and its vector store buffer.
package dmem_vec_responder_pkg;

    localparam int LANES  = 5;
    localparam int LIDX_W = 3;

    typedef enum logic {IDLE, DRAIN} state_e;
    typedef logic [LIDX_W-1:0] lidx_t;

endpackage

// File: rtl/dmem_vec_responder_vec_store_buffer.sv
// Holds vector lanes 1..LANES-1 after capture and presents them one per cycle for draining,
// plus a read-side match so pending lanes can be forwarded before they reach memory.
module vec_store_buffer
    import dmem_vec_responder_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      capture_i,
    input  logic                      advance_i,
    input  logic [AW-1:0]             base_i,
    input  logic [LANES-1:1][31:0]    lanes_i,
    input  logic [AW-1:0]             rd_idx_i,
    output logic [AW-1:0]             drain_addr_o,
    output logic [31:0]               drain_data_o,
    output logic                      drain_last_o,
    output logic                      fwd_hit_o,
    output logic [31:0]               fwd_data_o
);

    logic [AW-1:0]          base_q;
    logic [LANES-1:1][31:0] data_q;
    logic [LANES-1:1]       valid_q, valid_d;
    lidx_t                  cnt_q, cnt_d;
    logic [LANES-1:1]       cur_lane;

    always_comb begin
        cur_lane     = '0;
        drain_data_o = '0;
        fwd_hit_o    = 1'b0;
        fwd_data_o   = '0;
        for (int k = 1; k < LANES; k++) begin
            cur_lane[k] = (cnt_q == lidx_t'(k));
            if (cur_lane[k]) drain_data_o = data_q[k];
            // Lane addresses are distinct modulo DEPTH, so at most one lane can match.
            if (valid_q[k] && (AW'(base_q + AW'(k)) == rd_idx_i)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = data_q[k];
            end
        end
    end

    assign drain_addr_o = AW'(base_q + AW'(cnt_q));
    assign drain_last_o = (cnt_q == lidx_t'(LANES - 1));

    always_comb begin
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (capture_i) begin
            valid_d = '1;
            cnt_d   = lidx_t'(1);
        end else if (advance_i) begin
            valid_d = valid_q & ~cur_lane;
            cnt_d   = drain_last_o ? '0 : lidx_t'(cnt_q + lidx_t'(1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Payload needs no reset: it is only observed through valid_q.
    always_ff @(posedge clk) begin
        if (capture_i) begin
            base_q <= base_i;
            data_q <= lanes_i;
        end
    end

endmodule

// File: rtl/dmem_vec_responder.sv
// Data-memory responder: single-cycle scalar loads/stores plus 5-lane vector stores that
// write lane 0 immediately and drain the rest one per cycle while holding Stall high.
module dmem_vec_responder
    import dmem_vec_responder_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        VecWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    input  logic [31:0] VecWriteData_0,
    input  logic [31:0] VecWriteData_1,
    input  logic [31:0] VecWriteData_2,
    input  logic [31:0] VecWriteData_3,
    input  logic [31:0] VecWriteData_4,
    output logic [31:0] ReadData,
    output logic        Stall
);

    logic [31:0] mem_q [DEPTH];

    state_e                 state_q, state_d;
    logic [AW-1:0]          idx;
    logic [LANES-1:1][31:0] vec_hi;
    logic                   capture, advance;
    logic                   mem_we;
    logic [AW-1:0]          mem_waddr;
    logic [31:0]            mem_wdata;
    logic [AW-1:0]          drain_addr;
    logic [31:0]            drain_data;
    logic                   drain_last;
    logic                   fwd_hit;
    logic [31:0]            fwd_data;
    logic                   unused_addr_bits;

    assign idx              = ALUResult[AW+1:2];
    assign unused_addr_bits = ^{ALUResult[31:AW+2], ALUResult[1:0]};
    assign vec_hi           = {VecWriteData_4, VecWriteData_3, VecWriteData_2, VecWriteData_1};

    vec_store_buffer #(.AW(AW)) u_buf (
        .clk          (clk),
        .reset        (reset),
        .capture_i    (capture),
        .advance_i    (advance),
        .base_i       (idx),
        .lanes_i      (vec_hi),
        .rd_idx_i     (idx),
        .drain_addr_o (drain_addr),
        .drain_data_o (drain_data),
        .drain_last_o (drain_last),
        .fwd_hit_o    (fwd_hit),
        .fwd_data_o   (fwd_data)
    );

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        advance   = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = idx;
        mem_wdata = WriteData;
        unique case (state_q)
            IDLE: begin
                if (VecWrite) begin
                    capture   = 1'b1;
                    mem_we    = 1'b1;
                    mem_wdata = VecWriteData_0;
                    state_d   = DRAIN;
                end else if (MemWrite) begin
                    mem_we = 1'b1;
                end
            end
            DRAIN: begin
                // Core requests are ignored here; the core is holding its instruction.
                advance   = 1'b1;
                mem_we    = 1'b1;
                mem_waddr = drain_addr;
                mem_wdata = drain_data;
                if (drain_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!reset) mem_we = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign ReadData = fwd_hit ? fwd_data : mem_q[idx];
    assign Stall    = (state_q == DRAIN);

endmodule
